// File: rtl/fetch_sequencer_if.sv
// Bundle between fetch_sequencer, instruction memory and decode stage.
// FETCH_COUNTER_EN adds the fetch_count signal.
interface fetch_sequencer_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        halted;
  logic        fault;
`ifdef FETCH_COUNTER_EN
  logic [31:0] fetch_count;
`endif

  modport master (
`ifdef FETCH_COUNTER_EN
    output fetch_count,
`endif
    output imem_addr,
    input  imem_instr,
    input  stall,
    input  branch_taken,
    input  branch_target,
    output if_valid,
    output if_instr,
    output if_pc,
    output if_pc_plus4,
    output halted,
    output fault
  );

  modport slave (
`ifdef FETCH_COUNTER_EN
    input  fetch_count,
`endif
    input  imem_addr,
    output imem_instr,
    output stall,
    output branch_taken,
    output branch_target,
    input  if_valid,
    input  if_instr,
    input  if_pc,
    input  if_pc_plus4,
    input  halted,
    input  fault
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, fills the IF/ID register, stops on halt word or bad PC.
// Optional macro FETCH_COUNTER_EN adds a saturating count of accepted instructions.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_SIZE  = 1024,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input logic              clk,
  input logic              rst_n,
  fetch_sequencer_if.master bus
);

  localparam logic [31:0] LAST_PC = 32'(MEM_SIZE - 4);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HALT  = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  function automatic logic pc_legal(input logic [31:0] addr);
    return (addr[1:0] == 2'b00) && (addr <= LAST_PC);
  endfunction

`ifdef FETCH_COUNTER_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction
`endif

  state_t      state, state_next;
  logic [31:0] pc_p0, pc_next;
  logic        vld_p1, vld_next;
  logic [31:0] instr_p1, instr_next;
  logic [31:0] pc_p1, pc_p1_next;
  logic [31:0] pc4_p1, pc4_p1_next;
  logic        accept;
  logic [31:0] bad_addr;

  always_comb begin
    state_next  = state;
    pc_next     = pc_p0;
    vld_next    = vld_p1;
    instr_next  = instr_p1;
    pc_p1_next  = pc_p1;
    pc4_p1_next = pc4_p1;
    accept      = 1'b0;
    bad_addr    = pc_p0;

    unique case (state)
      S_FETCH: begin
        if (bus.branch_taken) begin
          // A branch wins over stall; the word currently at pc is wrong-path either way.
          vld_next = 1'b0;
          if (!pc_legal(bus.branch_target)) begin
            state_next = S_FAULT;
            bad_addr   = bus.branch_target;
          end else begin
            pc_next = bus.branch_target;
          end
        end else if (bus.stall) begin
          state_next = S_FETCH;
        end else if (!pc_legal(pc_p0)) begin
          // Checked before the halt compare so a bad PC faults even if memory returns the halt word.
          state_next = S_FAULT;
          vld_next   = 1'b0;
        end else if (bus.imem_instr == HALT_WORD) begin
          state_next = S_HALT;
          vld_next   = 1'b0;
        end else begin
          accept      = 1'b1;
          instr_next  = bus.imem_instr;
          pc_p1_next  = pc_p0;
          pc4_p1_next = pc_p0 + 32'd4;
          vld_next    = 1'b1;
          pc_next     = pc_p0 + 32'd4;
        end
      end
      S_HALT,
      S_FAULT: begin
        vld_next = 1'b0;
      end
      default: begin
        state_next = S_FAULT;
        vld_next   = 1'b0;
      end
    endcase
  end

  // ---- fetch stage (pc) / IF-ID register boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      pc_p0    <= RESET_PC;
      vld_p1   <= 1'b0;
      instr_p1 <= 32'd0;
      pc_p1    <= 32'd0;
      pc4_p1   <= 32'd0;
    end else begin
      state    <= state_next;
      pc_p0    <= pc_next;
      vld_p1   <= vld_next;
      instr_p1 <= instr_next;
      pc_p1    <= pc_p1_next;
      pc4_p1   <= pc4_p1_next;
    end
  end

`ifdef FETCH_COUNTER_EN
  logic [31:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 32'd0;
    end else if (accept) begin
      count_q <= sat_inc(count_q);
    end
  end

  assign bus.fetch_count = count_q;
`endif

  assign bus.imem_addr   = pc_p0;
  assign bus.if_valid    = vld_p1;
  assign bus.if_instr    = instr_p1;
  assign bus.if_pc       = pc_p1;
  assign bus.if_pc_plus4 = pc4_p1;
  assign bus.halted      = (state == S_HALT);
  assign bus.fault       = (state == S_FAULT);

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n && (state == S_FETCH) && (state_next == S_FAULT)) begin
      $warning("fetch_sequencer: illegal fetch address 0x%08h", bad_addr);
    end
  end
`endif

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller that sequences the byte-addressed, big-endian instruction memory.
- Owns the PC and drives the memory's combinational read address.
- Captures each fetched word into the IF/ID register, redirects on taken branches, and stops on the halt word (0xFFFFFFFF) or on an illegal fetch address.
- Sits between the instruction memory and the decode stage of the MIPS datapath.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- MEM_SIZE, 1024, instruction memory size in bytes; legal fetch PCs are 0..MEM_SIZE-4.
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- imem_addr  out  32  byte address to instruction memory; combinationally equal to pc.
- imem_instr  in  32  instruction word returned combinationally by memory for imem_addr.
- stall  in  1  decode stage cannot accept; hold PC and IF/ID contents.
- branch_taken  in  1  redirect request from execute stage.
- branch_target  in  32  redirect byte address, valid with branch_taken.
- if_valid  out  1  IF/ID holds a valid instruction.
- if_instr  out  32  IF/ID instruction.
- if_pc  out  32  PC of if_instr.
- if_pc_plus4  out  32  if_pc + 4.
- halted  out  1  halt word fetched; sticky.
- fault  out  1  illegal fetch address; sticky.

Behaviour:
- Reset (async assert, sync release):
  - pc=RESET_PC, state=FETCH.
  - if_valid=0, if_instr=0, if_pc=0, if_pc_plus4=0, halted=0, fault=0.
- States: FETCH, HALT, FAULT.
  - HALT and FAULT are terminal until rst_n is asserted.
- PC legality check: pc[1:0]==0 and pc <= MEM_SIZE-4.
- FETCH, per rising edge, in priority order:
  1. branch_taken=1:
     - branch_target illegal: state->FAULT, fault=1, pc unchanged, if_valid=0.
     - otherwise: pc<=branch_target, if_valid<=0 (flush wrong-path word).
     - Branch overrides a simultaneous stall.
  2. stall=1: pc, if_valid, if_instr, if_pc and if_pc_plus4 all hold.
  3. pc illegal: state->FAULT, fault=1, if_valid<=0.
  4. imem_instr==HALT_WORD: state->HALT, halted=1, if_valid<=0, pc holds. The halt word is never presented to decode.
  5. Otherwise:
     - if_instr<=imem_instr, if_pc<=pc, if_pc_plus4<=pc+4, if_valid<=1.
     - pc<=pc+4 (32-bit modulo; legality check catches overrun before wrap).
- Fetch latency: an instruction at PC p appears on if_instr one edge after pc==p with stall=0.
- Throughput: one instruction per cycle.
- Taken-branch penalty: one bubble.
- HALT and FAULT:
  - pc frozen, imem_addr=pc.
  - if_valid=0; if_instr and if_pc hold their last values.
  - stall and branch_taken ignored.
- Both halt and illegal conditions met in one cycle: FAULT wins.
- rst_n asserted mid-operation: all state clears immediately; fetch from RESET_PC restarts on the first edge after release.
- Simulation only: a display warning is printed on each entry to FAULT, showing the offending address.

Optional Feature:
- Macro FETCH_COUNTER_EN.
- Defined:
  - Adds output fetch_count (32 bits), reset to 0.
  - Increments by 1 on every edge where case 5 fires (instruction accepted into IF/ID).
  - Saturates at 32'hFFFF_FFFF.
  - Holds in HALT and FAULT.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Linear fetch:
  - Stimulus: reset with RESET_PC=0, memory holding words W0..W3 then 0xFFFFFFFF at byte 16; stall=0.
  - Required: if_instr = W0, W1, W2, W3 on edges 1-4 with if_pc = 0, 4, 8, 12; edge 5 gives halted=1, if_valid=0, imem_addr=16.
- Stall:
  - Stimulus: assert stall for 3 cycles while pc=8.
  - Required: if_pc=4 and pc=8 hold for 3 edges; edge after release gives if_pc=8, pc=12.
- Branch:
  - Stimulus: branch_taken=1, branch_target=32 while pc=20, with stall also high.
  - Required: next edge gives pc=32, if_valid=0; following edge gives if_pc=32, if_valid=1.
- Faults:
  - Stimulus: branch_target=6. Required: fault=1 next edge, pc unchanged.
  - Stimulus (separate run): linear run to pc=1020 with no halt word. Required: fetch at 1020 succeeds; pc=1024 then gives fault=1.
- Async reset mid-run:
  - Stimulus: drop rst_n between edges at pc=12.
  - Required: immediately if_valid=0, pc=0, halted=0, fault=0.
- FETCH_COUNTER_EN:
  - Stimulus: linear-fetch scenario with the macro defined.
  - Required: fetch_count=4 at halt and stays 4.
